// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 keyboard path.
//   - dec_state_t : scan-code decoder state encoding
//   - PS2_BREAK / PS2_EXT / PS2_PAUSE : set-2 prefix bytes
//   - is_ignored() : controller/status bytes that never form a key event
//   - EV_RELEASE / EV_EXT and make_event() : 16-bit key event layout
//     {release, extended, 6'b0, code[7:0]}
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    SKIP
  } dec_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Pause/Break emits E1 followed by seven more bytes that carry no key.
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  localparam int EV_RELEASE = 15;
  localparam int EV_EXT     = 14;

  // Error/ack/self-test bytes the keyboard may emit outside a key sequence.
  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE};
  endfunction

  function automatic logic [15:0] make_event(input logic       rel,
                                             input logic       ext,
                                             input logic [7:0] code);
    logic [15:0] ev;
    ev             = {8'h00, code};
    ev[EV_RELEASE] = rel;
    ev[EV_EXT]     = ext;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO with first-word-fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the clock edge (accepted when not full, or when
//                full and a pop happens in the same cycle)
//   pop        : retire the head entry (ignored when empty)
//   dout       : head entry, combinational; all zeros when empty
//   full, empty, count : status; count ranges 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible through
  // count/rd_ptr, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: decodes a PS/2 set-2 scan-code byte stream into 16-bit key
// events {release, extended, 6'b0, code} and queues them for the CPU.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   byte_valid : one-cycle strobe, byte_data holds a received frame
//   byte_data  : received scan-code byte
//   parity_err : frame was bad; byte dropped and decoder resynchronised
//   ren        : pop the head event at this clock edge
//   data       : head event (FWFT), 16'h0000 when empty
//   ready      : FIFO non-empty
//   overflow   : sticky, an event was dropped on a full FIFO
//   count      : occupancy 0..DEPTH
// Build option: define PS2_KEY_BREAK_EN to queue release events; otherwise
// break sequences are consumed silently and only make events are queued.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        parity_err,
  input  logic        ren,
  output logic [15:0] data,
  output logic        ready,
  output logic        overflow,
  output logic [AW:0] count
);

`ifdef PS2_KEY_BREAK_EN
  localparam logic BREAK_EN = 1'b1;
`else
  localparam logic BREAK_EN = 1'b0;
`endif

  dec_state_t  state, next_state;
  logic [2:0]  skip_cnt, next_skip;
  logic        push;
  logic [15:0] ev;
  logic        fifo_full;
  logic        fifo_empty;
  logic        good_byte;

  assign good_byte = byte_valid && !parity_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= next_state;
      skip_cnt <= next_skip;
    end
  end

  // Next-state logic. A bad frame abandons whatever sequence was in flight.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    next_state = state;
    next_skip  = skip_cnt;
    if (byte_valid && parity_err) begin
      next_state = IDLE;
      next_skip  = '0;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == PS2_BREAK)      next_state = BRK;
          else if (byte_data == PS2_EXT)   next_state = EXT;
          else if (byte_data == PS2_PAUSE) begin
            next_state = SKIP;
            next_skip  = PAUSE_SKIP_LEN;
          end
        end
        EXT:          next_state = (byte_data == PS2_BREAK) ? EXT_BRK : IDLE;
        BRK, EXT_BRK: next_state = IDLE;
        SKIP: begin
          // Guard on <=1 so a zero count can never strand the decoder here.
          if (skip_cnt <= 3'd1) begin
            next_state = IDLE;
            next_skip  = '0;
          end else begin
            next_skip = skip_cnt - 3'd1;
          end
        end
        default: begin
          next_state = IDLE;
          next_skip  = '0;
        end
      endcase
    end
  end

  // Output logic: which byte completes an event, and its flags.
  always_comb begin
    push = 1'b0;
    ev   = make_event(1'b0, 1'b0, byte_data);
    if (good_byte) begin
      case (state)
        IDLE: push = !(byte_data inside {PS2_BREAK, PS2_EXT, PS2_PAUSE}) &&
                     !is_ignored(byte_data);
        EXT: begin
          push = (byte_data != PS2_BREAK);
          ev   = make_event(1'b0, 1'b1, byte_data);
        end
        BRK: begin
          push = BREAK_EN;
          ev   = make_event(1'b1, 1'b0, byte_data);
        end
        EXT_BRK: begin
          push = BREAK_EN;
          ev   = make_event(1'b1, 1'b1, byte_data);
        end
        default: push = 1'b0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (ev),
    .pop   (ren),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign ready = !fifo_empty;

  // A full FIFO is never empty, so ren alone decides whether room opens up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overflow <= 1'b0;
    else if (push && fifo_full && !ren)  overflow <= 1'b1;
  end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Decodes the raw PS/2 scan-code byte stream (set 2) into 16-bit key events and buffers them for the CPU. It sits between the PS/2 serial receiver, which delivers one byte per frame, and the memory-mapped keyboard port in `mem`. It presents the same `ren` / `data` / `ready` read interface that `mem` already consumes. It handles the `F0` break prefix, the `E0` extended prefix and the `E1` pause sequence.

## Interface
- `DEPTH`, 16: number of FIFO entries; power of two, ≥2.
- `AW`, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk`  in  1  system clock (50 MHz core clock)
- `reset`  in  1  asynchronous, active-low reset
- `byte_valid`  in  1  one-cycle strobe; `byte_data` holds a received frame
- `byte_data`  in  8  received scan-code byte
- `parity_err`  in  1  qualifies `byte_valid`; frame had a bad parity or stop bit
- `ren`  in  1  pop head entry at this clock edge
- `data`  out  16  head event `{release, extended, 6'b0, code[7:0]}`; `16'h0000` when empty
- `ready`  out  1  FIFO non-empty
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full
- `count`  out  AW+1  current occupancy, 0..DEPTH

## Operation
- Decoder FSM states: `IDLE`, `BRK`, `EXT`, `EXT_BRK`, `SKIP`.
  - `IDLE`:
    - `F0` → `BRK`
    - `E0` → `EXT`
    - `E1` → `SKIP` with skip counter = 7
    - `00`, `FF`, `AA`, `FA`, `FE` → drop, stay in `IDLE`
    - any other code → push `{0,0,code}`
  - `EXT`:
    - `F0` → `EXT_BRK`
    - other code → push `{0,1,code}`, → `IDLE`
  - `BRK`: any byte → push `{1,0,code}`, → `IDLE`
  - `EXT_BRK`: any byte → push `{1,1,code}`, → `IDLE`
  - `SKIP`: each byte decrements the counter; the byte that reaches 0 → `IDLE`. No push.
- `byte_valid` with `parity_err`=1: byte discarded, FSM forced to `IDLE`, skip counter cleared.
- FIFO:
  - Circular buffer with AW-bit read/write pointers plus occupancy counter.
  - First-word-fall-through: `data` is driven combinationally from the head entry.
- Push accepted when `count < DEPTH`, or when `count == DEPTH` and `ren` pops in the same cycle.
  - Otherwise the event is dropped and `overflow` sets.
  - `overflow` clears only on reset.
- `ren` with `count == 0`: ignored; no pointer movement and no underflow.
- Simultaneous push and pop: `count` unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values (asynchronous): FSM `IDLE`, skip counter 0, pointers 0, `count` 0, `ready` 0, `data` 16'h0000, `overflow` 0.
- Asserting reset mid-sequence (e.g. after `F0`) discards the partial sequence and all queued events.
- Write latency:
  - Final byte strobed in cycle N; entry written at the end of N.
  - `ready` = 1 and `data` valid in cycle N+1.
- Pop:
  - `ren` sampled at the edge ending cycle M.
  - Next entry, or `16'h0000` if the FIFO is now empty, is on `data` in M+1.
- Back-to-back: one event per cycle in and one per cycle out are both sustained.
- `byte_valid` is never asserted on consecutive cycles by the receiver; the block does not depend on this.

## Configuration
- `PS2_KEY_BREAK_EN`:
  - Defined: release events (`release`=1) are queued as above.
  - Undefined: the FSM still tracks `BRK` / `EXT_BRK` to consume the break code, but the push is suppressed. Only make events reach the FIFO and `data[15]` is always 0.

## Structure
- Shared package `ps2_pkg`:
  - FSM state encoding.
  - Prefix constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_PAUSE`=8'hE1.
  - Ignored-code list.
  - Event bit positions (`EV_RELEASE`=15, `EV_EXT`=14).
- One sub-module, `sync_fifo`:
  - Parameterised width/depth.
  - Push/pop/full/empty/count.
  - FWFT read.
  - Reused later for the UART RX path.
- The decoder FSM lives in `ps2_key_fifo` itself.

## Test plan
- Reset, send `1C` → `ready`=1 one cycle after the strobe, `data`=16'h001C; pulse `ren` → `ready`=0, `data`=16'h0000.
- Send `F0 1C` then `E0 F0 75` → pops yield 16'h801C then 16'hC075. Without `PS2_KEY_BREAK_EN`: FIFO stays empty.
- Send `E1 14 77 E1 F0 14 F0 77` then `1C` → exactly one entry, 16'h001C.
- Send 17 make codes `01`..`11` with no reads → `count`=16, `overflow`=1. Pops return 16'h0001..16'h0010; `11` is lost. Repeat with `ren` asserted on the 17th push cycle → `11` is accepted and `overflow` stays 0.
- Send `F0`, assert reset, release, send `1C` → 16'h001C (no release bit). Send `E0` with `parity_err`=1, then `75` → 16'h0075.
- `ren` pulsed while empty, then `1C` → `count`=1, `data`=16'h001C; pointers not corrupted.
